// File: rtl/imem_arb.sv
// Instruction-memory arbiter: fetch / program loader onto one synchronous RAM port.
// Optional fetch-stall performance counter is enabled by defining IMEM_ARB_PERF_EN.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | loader owns the RAM exclusively; fetch is held off until l_done
// RUN   | fetch has priority; loader is forced through after STARVE_LIMIT denials
module imem_arb #(
    parameter int XLEN            = 32,
    parameter int WORD_ADDR_WIDTH = 10,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_req,
    input  logic [WORD_ADDR_WIDTH-1:0] f_addr,
    output logic                       f_gnt,
    output logic                       f_rvalid,
    output logic [XLEN-1:0]            f_rdata,
    input  logic                       l_req,
    input  logic                       l_we,
    input  logic [WORD_ADDR_WIDTH-1:0] l_addr,
    input  logic [XLEN-1:0]            l_wdata,
    input  logic                       l_done,
    output logic                       l_gnt,
    output logic                       l_rvalid,
    output logic [XLEN-1:0]            l_rdata,
    output logic                       m_en,
    output logic                       m_we,
    output logic [WORD_ADDR_WIDTH-1:0] m_addr,
    output logic [XLEN-1:0]            m_wdata,
    input  logic [XLEN-1:0]            m_rdata,
    output logic                       boot_active,
    output logic [31:0]                perf_fetch_stall
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [7:0] starve_cnt, starve_nxt;
    logic       force_l;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN is terminal; only reset returns to BOOT.
    always_comb begin
        state_nxt = state;
        if (state == ST_BOOT && l_done) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        force_l = 1'b0;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (state == ST_BOOT) begin
            l_gnt = l_req;
        end else begin
            force_l = (starve_cnt == LIMIT) && l_req;
            if (force_l) begin
                l_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
                l_gnt = l_req && !f_req;
            end
        end
        if (f_gnt) begin
            m_en   = 1'b1;
            m_addr = f_addr;
        end else if (l_gnt) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    // Consecutive denied loader cycles; only meaningful in RUN.
    always_comb begin
        starve_nxt = 8'd0;
        if (state == ST_RUN && l_req && !l_gnt) begin
            starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 8'd0;
            f_rvalid   <= 1'b0;
            l_rvalid   <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            f_rvalid   <= f_gnt;
            l_rvalid   <= l_gnt && !l_we;
        end
    end

    assign f_rdata     = m_rdata;
    assign l_rdata     = m_rdata;
    assign boot_active = (state == ST_BOOT);

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (f_req && !f_gnt && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_stall = stall_cnt;
`else
    assign perf_fetch_stall = 32'd0;
`endif

endmodule

// File: doc/imem_arb.md
# imem_arb

Single-port instruction-memory arbiter sitting between the fetch stage, the program loader and the synchronous instruction RAM. A two-state controller gives the loader exclusive access during boot, then gives fetch priority at run time. A starvation counter guarantees loader progress. Read data returns one cycle after grant, tagged per requester.

## Interface
Parameters:
- XLEN, 32, data width
- WORD_ADDR_WIDTH, 10, word-address width of the RAM
- STARVE_LIMIT, 4, consecutive denied loader cycles in RUN before the loader is forced through; legal range 1..255

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- f_req  in  1  fetch read request
- f_addr  in  WORD_ADDR_WIDTH  fetch word address
- f_gnt  out  1  fetch access issued this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  XLEN  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  WORD_ADDR_WIDTH  loader word address
- l_wdata  in  XLEN  loader write data
- l_done  in  1  one-cycle pulse: program load complete
- l_gnt  out  1  loader access issued this cycle
- l_rvalid  out  1  loader read data valid; never asserted for writes
- l_rdata  out  XLEN  loader read data
- m_en  out  1  RAM enable
- m_we  out  1  RAM write enable
- m_addr  out  WORD_ADDR_WIDTH  RAM address
- m_wdata  out  XLEN  RAM write data
- m_rdata  in  XLEN  RAM read data, valid the cycle after m_en & ~m_we
- boot_active  out  1  high while in BOOT
- perf_fetch_stall  out  32  fetch-stall counter (see Configuration)

## Operation
- States: BOOT (reset state) and RUN. There is no path from RUN back to BOOT except reset.
- BOOT behaviour:
  - l_gnt = l_req; f_gnt = 0.
  - l_done moves the block to RUN on the next edge.
  - An l_req in the same cycle as l_done is still served as a BOOT access.
- RUN behaviour:
  - force = (starve_cnt == STARVE_LIMIT) & l_req.
  - If force: l_gnt = 1, f_gnt = 0.
  - Otherwise: f_gnt = f_req, and l_gnt = l_req & ~f_req.
  - l_done is ignored.
- starve_cnt is 8 bits and exists only in RUN.
  - Increments when l_req & ~l_gnt.
  - Clears on l_gnt, or when l_req is low.
  - Saturates at STARVE_LIMIT.
- At most one grant per cycle. f_gnt and l_gnt are never both high.
- Memory drive on fetch grant: m_en = 1, m_we = 0, m_addr = f_addr.
- Memory drive on loader grant: m_en = 1, m_we = l_we, m_addr = l_addr, m_wdata = l_wdata.
- With no grant: m_en = 0, m_we = 0; m_addr and m_wdata are don't-care and held at 0.
- Read data: f_rdata = m_rdata and l_rdata = m_rdata, unconditionally. Consumers qualify with rvalid.
- A requester that is not granted keeps its request and address stable until granted. Fetch normally does this by stalling the PC.

## Timing
- Grants are combinational from the requests and the current state, in the same cycle.
- Read latency is 1 cycle.
  - f_rvalid is registered and set to f_gnt.
  - l_rvalid is registered and set to l_gnt & ~l_we.
- Back-to-back grants are allowed every cycle, with full throughput for each requester.
- Reset values:
  - State BOOT, starve_cnt 0.
  - f_rvalid 0, l_rvalid 0, perf_fetch_stall 0.
  - boot_active 1, f_gnt 0, m_en 0.
- Reset asserted mid-access: pending rvalid flags clear immediately (asynchronously). The in-flight read is dropped.
- The BOOT→RUN transition takes effect on the clock edge after l_done. The first possible f_gnt is in the following cycle.

## Configuration
- Macro IMEM_ARB_PERF_EN.
- Defined: perf_fetch_stall counts cycles with f_req & ~f_gnt, in both BOOT and RUN.
  - 32-bit counter, saturating at 0xFFFF_FFFF.
  - Cleared only by reset.
- Undefined: no counter is instantiated and perf_fetch_stall is tied to 0.

## Test plan
- Boot load: write 0xDEADBEEF to address 3, then issue l_done. Hold f_req=1 throughout.
  - f_gnt stays 0 until the cycle after l_done.
  - A fetch read of address 3 then returns f_rvalid=1 and f_rdata=0xDEADBEEF one cycle after f_gnt.
- Fetch priority in RUN: hold f_req=1 and l_req=1 with STARVE_LIMIT=4.
  - Fetch is granted for 4 cycles.
  - Loader is granted in the 5th cycle, and starve_cnt returns to 0.
  - The pattern repeats every 5 cycles.
- Loader read in RUN with f_req=0: l_gnt is high the same cycle; l_rvalid rises 1 cycle later; f_rvalid stays 0.
- Simultaneous l_req (write) and l_done in BOOT:
  - The write is granted that cycle.
  - boot_active drops on the next edge.
  - A readback of the address returns the written data.
- Assert reset asynchronously in the cycle after a fetch grant:
  - f_rvalid drops to 0 immediately.
  - boot_active = 1 and perf_fetch_stall = 0.
- With IMEM_ARB_PERF_EN defined: hold f_req=1 for 10 cycles in BOOT, then 1 cycle → perf_fetch_stall = 10. Without the macro it reads 0.
